// File: rtl/tcm_mem_port_if.sv
// tcm_mem_port_if: request/response channel between a requester and the TCM port adapter
interface tcm_mem_port_if #(parameter int TAG_W = 4);
  logic             req_valid_i;
  logic             req_accept_o;
  logic [31:0]      req_addr_i;
  logic [3:0]       req_wr_i;
  logic [31:0]      req_data_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  logic [31:0]      resp_data_o;
  logic [TAG_W-1:0] resp_tag_o;
  logic             resp_error_o;
  modport master (
    output req_valid_i, req_addr_i, req_wr_i, req_data_i, req_tag_i, resp_ready_i,
    input  req_accept_o, resp_valid_o, resp_data_o, resp_tag_o, resp_error_o
  );
  modport slave (
    input  req_valid_i, req_addr_i, req_wr_i, req_data_i, req_tag_i, resp_ready_i,
    output req_accept_o, resp_valid_o, resp_data_o, resp_tag_o, resp_error_o
  );
endinterface

// File: rtl/tcm_mem_port.sv
// tcm_mem_port: 32-bit tagged request/response adapter onto one 64-bit byte-enabled TCM RAM port
module tcm_mem_port #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          TAG_W      = 4,
  parameter int          RESP_DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  tcm_mem_port_if.slave bus,
  output logic [12:0]  ram_addr_o,
  output logic [63:0]  ram_data_o,
  output logic [7:0]   ram_wr_o,
  input  logic [63:0]  ram_data_i
);
  localparam int PW = RESP_DEPTH > 1 ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(RESP_DEPTH - 1);
  logic             fire, err, push, pop, empty;
  logic             inf_v_q, inf_lane_q, inf_wr_q, inf_err_q;
  logic [TAG_W-1:0] inf_tag_q;
  logic [31:0]      cand_data;
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      buf_data [RESP_DEPTH];
  logic [TAG_W-1:0] buf_tag  [RESP_DEPTH];
  logic             buf_err  [RESP_DEPTH];
  always_comb begin
    err              = bus.req_addr_i[31:16] != BASE_ADDR[31:16];
    bus.req_accept_o = ~rst_i & ((cnt_q + CW'(inf_v_q)) < CW'(RESP_DEPTH));
    fire             = bus.req_valid_i & bus.req_accept_o;
    ram_addr_o       = bus.req_addr_i[15:3];
    ram_data_o       = {bus.req_data_i, bus.req_data_i};
    ram_wr_o         = fire & ~err ? (bus.req_addr_i[2] ? {bus.req_wr_i, 4'b0} : {4'b0, bus.req_wr_i}) : 8'h00;
    empty            = cnt_q == '0;
    cand_data        = inf_wr_q | inf_err_q ? 32'h0 : inf_lane_q ? ram_data_i[63:32] : ram_data_i[31:0];
    // A response the requester takes immediately skips the buffer entirely
    push             = inf_v_q & ~(empty & bus.resp_ready_i);
    pop              = ~empty & bus.resp_ready_i;
    cnt_d            = cnt_q + CW'(push) - CW'(pop);
    wp_d             = push ? (wp_q == LAST ? '0 : wp_q + 1'b1) : wp_q;
    rp_d             = pop ? (rp_q == LAST ? '0 : rp_q + 1'b1) : rp_q;
    bus.resp_valid_o = ~empty | inf_v_q;
    bus.resp_data_o  = ~empty ? buf_data[rp_q] : inf_v_q ? cand_data : 32'h0;
    bus.resp_tag_o   = ~empty ? buf_tag[rp_q] : inf_v_q ? inf_tag_q : '0;
    bus.resp_error_o = ~empty ? buf_err[rp_q] : inf_v_q & inf_err_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inf_v_q    <= 1'b0;
      inf_lane_q <= 1'b0;
      inf_wr_q   <= 1'b0;
      inf_err_q  <= 1'b0;
      inf_tag_q  <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
    end else begin
      inf_v_q    <= fire;
      inf_lane_q <= bus.req_addr_i[2];
      inf_wr_q   <= |bus.req_wr_i;
      inf_err_q  <= err;
      inf_tag_q  <= bus.req_tag_i;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_data[wp_q] <= cand_data;
      buf_tag[wp_q]  <= inf_tag_q;
      buf_err[wp_q]  <= inf_err_q;
    end
  end
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= CW'(RESP_DEPTH));
endmodule

// File: tb/tb_tcm_mem_port.sv
// tb_tcm_mem_port: scoreboard bench for tcm_mem_port with a read-first RAM model
module tb_tcm_mem_port;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [12:0] ram_addr;
  logic [63:0] ram_wdata, ram_rdata;
  logic [7:0]  ram_wr;
  logic [63:0] ram    [8192];
  logic [63:0] shadow [8192];
  logic [36:0] sb [$];
  int          tests = 0, fails = 0, last_wait = 0;
  always #5 clk_i = ~clk_i;
  tcm_mem_port_if #(.TAG_W(4)) bus();
  tcm_mem_port #(.BASE_ADDR(32'h0), .TAG_W(4), .RESP_DEPTH(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus),
    .ram_addr_o(ram_addr), .ram_data_o(ram_wdata), .ram_wr_o(ram_wr), .ram_data_i(ram_rdata)
  );
  always @(posedge clk_i) begin
    ram_rdata <= ram[ram_addr];
    for (int b = 0; b < 8; b++)
      if (ram_wr[b]) ram[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk_i) begin
    if (!rst_i && bus.resp_valid_o && bus.resp_ready_i) begin
      if (sb.size() == 0) chk("resp_unexpected", 64'(sb.size()), 64'd1);
      else chk("resp", {bus.resp_tag_o, bus.resp_error_o, bus.resp_data_o}, sb.pop_front());
    end
  end
  task automatic note();
    logic [12:0] w  = bus.req_addr_i[15:3];
    logic        l  = bus.req_addr_i[2];
    logic        e  = bus.req_addr_i[31:16] != 16'h0;
    logic [3:0]  st = bus.req_wr_i;
    logic [7:0]  ew = e ? 8'h00 : l ? {st, 4'h0} : {4'h0, st};
    chk("ram_wr", ram_wr, ew);
    sb.push_back({bus.req_tag_i, e, (e || st != 0) ? 32'h0 : (l ? shadow[w][63:32] : shadow[w][31:0])});
    if (!e)
      for (int b = 0; b < 4; b++)
        if (st[b]) shadow[w][int'(l)*32 + b*8 +: 8] = bus.req_data_i[b*8 +: 8];
  endtask
  task automatic issue(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d, input logic [3:0] t);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = a;
    bus.req_wr_i    = w;
    bus.req_data_i  = d;
    bus.req_tag_i   = t;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (bus.req_accept_o) begin
        last_wait = i;
        note();
        @(posedge clk_i); #1;
        bus.req_valid_i = 1'b0;
        return;
      end
      @(posedge clk_i); #1;
    end
    chk("accept_timeout", 64'(bus.req_accept_o), 64'd1);
    bus.req_valid_i = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk_i);
    #1;
    chk("drain", 64'(sb.size()), 64'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    logic acc;
    logic [3:0] t;
    bus.req_valid_i  = 1'b1;
    bus.req_addr_i   = 32'h8;
    bus.req_wr_i     = 4'hF;
    bus.req_data_i   = 32'h0;
    bus.req_tag_i    = 4'h0;
    bus.resp_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_accept", 64'(bus.req_accept_o), 64'd0);
    chk("rst_valid",  64'(bus.resp_valid_o), 64'd0);
    chk("rst_data",   64'(bus.resp_data_o), 64'd0);
    chk("rst_tag",    64'(bus.resp_tag_o), 64'd0);
    chk("rst_error",  64'(bus.resp_error_o), 64'd0);
    chk("rst_ram_wr", 64'(ram_wr), 64'd0);
    bus.req_valid_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_accept", 64'(bus.req_accept_o), 64'd1);
    @(posedge clk_i); #1;
    issue(32'h8, 4'hF, 32'h1111_2222, 4'd1);
    issue(32'hC, 4'hF, 32'hAAAA_BBBB, 4'd2);
    issue(32'h0, 4'hF, 32'h9ABC_DEF0, 4'd3);
    issue(32'h4, 4'hF, 32'h1234_5678, 4'd4);
    drain();
    issue(32'h8, 4'h0, 32'h0, 4'd5);
    @(negedge clk_i);
    chk("lat1_valid", 64'(bus.resp_valid_o), 64'd1);
    chk("rd_lo", 64'(bus.resp_data_o), 64'h1111_2222);
    @(posedge clk_i); #1;
    issue(32'hC, 4'h0, 32'h0, 4'd6);
    @(negedge clk_i);
    chk("rd_hi", 64'(bus.resp_data_o), 64'hAAAA_BBBB);
    @(posedge clk_i); #1;
    drain();
    issue(32'h4, 4'b0101, 32'hDEAD_BEEF, 4'd7);
    issue(32'h4, 4'h0, 32'h0, 4'd8);
    @(negedge clk_i);
    chk("rmw", 64'(bus.resp_data_o), 64'h12AD_56EF);
    @(posedge clk_i); #1;
    drain();
    for (int i = 1; i <= 8; i++) begin
      issue(32'h8 + 32'((i % 2) * 4), 4'h0, 32'h0, 4'(i));
      chk("b2b_wait", 64'(last_wait), 64'd0);
    end
    drain();
    bus.resp_ready_i = 1'b0;
    t = 4'd9;
    n = 0;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h8;
    bus.req_wr_i    = 4'h0;
    bus.req_tag_i   = t;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      acc = bus.req_accept_o;
      if (acc) begin
        note();
        n++;
      end
      @(posedge clk_i); #1;
      if (acc) begin
        t = t + 4'd1;
        bus.req_tag_i = t;
      end
    end
    chk("stall_count", 64'(n), 64'd2);
    @(negedge clk_i);
    chk("stall_accept", 64'(bus.req_accept_o), 64'd0);
    @(posedge clk_i); #1;
    bus.req_valid_i  = 1'b0;
    bus.resp_ready_i = 1'b1;
    drain();
    @(negedge clk_i);
    chk("accept_back", 64'(bus.req_accept_o), 64'd1);
    @(posedge clk_i); #1;
    issue(32'h0001_0000, 4'hF, 32'hFFFF_FFFF, 4'd10);
    issue(32'h0, 4'h0, 32'h0, 4'd11);
    @(negedge clk_i);
    chk("err_ram_kept", 64'(bus.resp_data_o), 64'h9ABC_DEF0);
    @(posedge clk_i); #1;
    drain();
    bus.resp_ready_i = 1'b0;
    issue(32'h8, 4'h0, 32'h0, 4'd12);
    issue(32'hC, 4'h0, 32'h0, 4'd13);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst_async_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("rst_async_accept", 64'(bus.req_accept_o), 64'd0);
    sb.delete();
    bus.resp_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      chk("no_stale", 64'(bus.resp_valid_o), 64'd0);
    end
    chk("rst2_accept", 64'(bus.req_accept_o), 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
